// File: rtl/vram_write_queue_if.sv
// vram_write_queue_if: CPU write-request and VRAM write-port bundle for vram_write_queue
interface vram_write_queue_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ADDR_WIDTH-1:0]   in_address;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    flush;
    logic                    writable;
    logic                    out_wr;
    logic [ADDR_WIDTH-1:0]   out_address;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [$clog2(DEPTH):0]  count;
    logic                    empty;
    modport master (
        output in_valid, in_address, in_data, flush, writable,
        input  in_ready, out_wr, out_address, out_data, count, empty
    );
    modport slave (
        input  in_valid, in_address, in_data, flush, writable,
        output in_ready, out_wr, out_address, out_data, count, empty
    );
endinterface

// File: rtl/vram_write_queue.sv
// vram_write_queue: FIFO of CPU VRAM writes, drained one per clock while the video window is writable
module vram_write_queue #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input logic               clk,
    input logic               rst,
    vram_write_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] count_nxt;
    logic push, pop;
    assign bus.in_ready = (bus.count != FULL_CNT) && !bus.flush;
    assign push = bus.in_valid && bus.in_ready;
    // empty is the registered flag, so a push into an empty queue never falls through the same edge
    assign pop = bus.writable && !bus.empty && !bus.flush;
    always_comb begin
        count_nxt = (push && !pop) ? bus.count + CW'(1) :
                    (pop && !push) ? bus.count - CW'(1) : bus.count;
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {bus.in_address, bus.in_data};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp              <= '0;
            rp              <= '0;
            bus.count       <= '0;
            bus.empty       <= 1'b1;
            bus.out_wr      <= 1'b0;
            bus.out_address <= '0;
            bus.out_data    <= '0;
        end else if (bus.flush) begin
            wp         <= '0;
            rp         <= '0;
            bus.count  <= '0;
            bus.empty  <= 1'b1;
            bus.out_wr <= 1'b0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop) begin
                rp <= rp + PW'(1);
                {bus.out_address, bus.out_data} <= mem[rp];
            end
            bus.out_wr <= pop;
            bus.count  <= count_nxt;
            bus.empty  <= count_nxt == '0;
        end
    end
endmodule

// File: doc/vram_write_queue.md
Name: vram_write_queue

Overview:
- Buffers CPU-side VRAM write requests (address, data) in a FIFO.
- Drains them onto the GPU's VRAM write port one per clock, only while the video timing reports the writable window.
- Sits directly upstream of the GPU's VRAM interface (data/address inputs); the writable flag comes from the video timing generator.
- Lets the CPU post writes at any time without corrupting active scanout.

Parameters:
ADDR_WIDTH, 12, VRAM address width; must equal the GPU's VRAM address width.
DATA_WIDTH, 8, VRAM data width.
DEPTH, 16, FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  pixel clock (12.5875 MHz)
rst  input  1  synchronous active-high reset
in_valid  input  1  CPU write request present
in_ready  output  1  queue can accept a request this cycle
in_address  input  ADDR_WIDTH  VRAM target address
in_data  input  DATA_WIDTH  VRAM write data
flush  input  1  discard all queued entries
writable  input  1  VRAM write window open (from video timing)
out_wr  output  1  write strobe to VRAM, one cycle per entry
out_address  output  ADDR_WIDTH  VRAM address, valid when out_wr=1
out_data  output  DATA_WIDTH  VRAM data, valid when out_wr=1
count  output  $clog2(DEPTH)+1  entries currently queued
empty  output  1  count==0

Behaviour:
Clocking and reset:
- One clock (clk); reset is synchronous and active-high (rst).
- rst sampled high clears:
  - read/write pointers and count to 0
  - out_wr, out_address, out_data to 0
  - empty to 1; in_ready to 1 on the following cycle.

Write side:
- in_ready = !full && !flush, where full is count==DEPTH. This is combinational from the registered count plus the flush input.
- Push occurs at the edge where in_valid && in_ready; the entry is stored at the write pointer.
- Requests with in_valid && !in_ready are not accepted. The CPU must hold them; the queue does not drop or flag them.

Read side:
- Pop occurs at the edge where writable && !empty && !flush.
- Registered outputs after a pop edge: out_wr=1, out_address and out_data = head entry, for exactly one cycle.
- No pop at an edge: out_wr=0; out_address and out_data hold their last values.
- At most one pop per cycle. Entries leave strictly in FIFO order.

Latency and throughput:
- Entry accepted at edge E0 can appear on out_wr no earlier than the cycle after edge E1 (two edges), provided writable=1 at E1.
- Sustained throughput is one write per clock while writable is high and the queue is non-empty.

Writable gating:
- writable is sampled at the pop edge only.
- The last out_wr pulse may extend one cycle past writable falling. The GPU accepts writes in that trailing cycle.

Simultaneous events:
- Push and pop at the same edge: count unchanged, both pointers advance. This is legal at any count in 1..DEPTH-1.
- When full, in_ready=0, so no push occurs even if a pop happens that edge.
- When empty, a push with writable=1 does not pop the same entry that edge; no fall-through.

Pointers and count:
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count is an explicit register: +1 on push only, -1 on pop only.

Flush:
- flush sampled high sets pointers and count to 0 and out_wr to 0 at that edge.
- Push and pop are suppressed during the flush cycle.
- Priority: rst > flush > push/pop.

Status:
- count and empty are registered and reflect state after the last edge.
- Reset or flush mid-burst truncates the burst cleanly. No partial or duplicate out_wr pulses.

Test Plan:
1. Reset: hold rst 2 cycles with in_valid=1 -> out_wr=0, count=0, empty=1; in_ready=1 the cycle after rst drops.
2. Single write: writable=1, push (0x123, 0xA5) at edge 0 -> out_wr=1 with address 0x123, data 0xA5 in the cycle after edge 1 only; count returns to 0.
3. Fill and drain:
   - With writable=0, push 17 requests: entries 0..15 accepted; in_ready=0 once count=16; 17th held.
   - Raise writable for 20 cycles -> 16 consecutive out_wr pulses in order, then the 17th entry (accepted after the first pop frees space).
4. Window gating: 8 entries queued; writable high 3 cycles, low 10, high again -> exactly 3 pulses, then none during the low window (pulses end within 1 cycle of the fall), then the remaining 5 in order.
5. Simultaneous push/pop and wrap: hold count=1 while pushing and popping every cycle for 40 cycles -> count stays 1, pointers wrap twice, the output sequence matches the input sequence.
6. Flush mid-drain: 10 entries queued, draining; assert flush at pulse 4 -> out_wr=0 next cycle, count=0, no further pulses; a new push afterwards drains normally.
